// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: arbitrates I-cache (port 0) and D-cache (port 1) misses onto the L2 bus; burst reads, single-beat writes.
// Define L2_ARB_FIXED_PRIO_EN to make port 1 win simultaneous requests instead of round-robin.
module l2_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_rd_en,
    input  logic              p0_wr_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wr_data,
    output logic              p0_rd_granted,
    output logic              p0_wr_granted,
    input  logic              p1_rd_en,
    input  logic              p1_wr_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    output logic              p1_rd_granted,
    output logic              p1_wr_granted,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_rd_en,
    output logic              l2_wr_en,
    output logic [DATA_W-1:0] l2_wr_data,
    input  logic [DATA_W-1:0] l2_rd_data
);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        req;
    logic              win, own_rd_en, rd_gnt, wr_gnt;

    assign req       = {p1_rd_en | p1_wr_en, p0_rd_en | p0_wr_en};
    assign own_rd_en = owner_q ? p1_rd_en : p0_rd_en;
    assign rd_gnt    = state_q == RD && own_rd_en;
    assign wr_gnt    = state_q == WR;

`ifdef L2_ARB_FIXED_PRIO_EN
    assign win = req[1];
`else
    logic last_q, last_d;
    assign win = &req ? ~last_q : req[1];
    always_comb last_d = (state_q != IDLE && state_d == IDLE) ? owner_q : last_q;
    always_ff @(posedge clk) last_q <= !rst_n ? 1'b1 : last_d;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        rd_pend_d = rd_gnt;
        rd_data_d = rd_pend_q ? l2_rd_data : rd_data_q;
        case (state_q)
            IDLE: if (|req) begin
                owner_d = win;
                state_d = (win ? p1_wr_en : p0_wr_en) ? WR : RD;
                cnt_d   = '0;
            end
            RD: if (!own_rd_en) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_W'(BURST_LEN)) state_d = IDLE;
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign p0_rd_granted = rd_gnt && !owner_q;
    assign p1_rd_granted = rd_gnt && owner_q;
    assign p0_wr_granted = wr_gnt && !owner_q;
    assign p1_wr_granted = wr_gnt && owner_q;
    assign l2_rd_en      = rd_gnt;
    assign l2_wr_en      = wr_gnt;
    assign l2_addr       = (rd_gnt || wr_gnt) ? (owner_q ? p1_addr : p0_addr) : '0;
    assign l2_wr_data    = wr_gnt ? (owner_q ? p1_wr_data : p0_wr_data) : '0;
    assign rd_data       = rd_data_q;
endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb_l2_bus_arbiter: directed vector table, corner sequences and random traffic against a transaction-level model.
module tb_l2_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    rd_en, wr_en, rdg, wrg;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] rd_data, l2_wr_data, l2_rd_data;
    logic [AW-1:0] l2_addr;
    logic          l2_rd_en, l2_wr_en;
    int            errors = 0;
    int            checks = 0;

    // model: current bus owner (-1 = arbitrating), its transfer kind, beats done, last finished owner
    int            cur = -1;
    bit            cur_wr;
    int            beats;
    int            last = 1;
    bit            prev_rd;
    logic [DW-1:0] exp_rd;
    logic [1:0]    m_rdg, m_wrg;

    typedef struct {
        logic [1:0]    rd, wr;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    erg, ewg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
    } vec_t;
    vec_t       tbl [18];
    logic [1:0] alt_exp [12];
    logic [1:0] tie_exp;

    always #5 clk = ~clk;

    l2_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_rd_en(rd_en[0]), .p0_wr_en(wr_en[0]), .p0_addr(addr[0]), .p0_wr_data(wdata[0]),
        .p0_rd_granted(rdg[0]), .p0_wr_granted(wrg[0]),
        .p1_rd_en(rd_en[1]), .p1_wr_en(wr_en[1]), .p1_addr(addr[1]), .p1_wr_data(wdata[1]),
        .p1_rd_granted(rdg[1]), .p1_wr_granted(wrg[1]),
        .rd_data(rd_data), .l2_addr(l2_addr), .l2_rd_en(l2_rd_en), .l2_wr_en(l2_wr_en),
        .l2_wr_data(l2_wr_data), .l2_rd_data(l2_rd_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] req);
`ifdef L2_ARB_FIXED_PRIO_EN
        return req[1] ? 1 : 0;
`else
        return req == 2'b11 ? 1 - last : (req[1] ? 1 : 0);
`endif
    endfunction

    task automatic sample();
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        @(negedge clk);
        m_rdg = '0;
        m_wrg = '0;
        ea    = '0;
        ewd   = '0;
        if (cur >= 0) begin
            if (cur_wr) m_wrg[cur] = 1'b1;
            else m_rdg[cur] = rd_en[cur];
        end
        if (|(m_rdg | m_wrg)) ea = addr[cur];
        if (|m_wrg) ewd = wdata[cur];
        chk("rd_granted", 64'(rdg), 64'(m_rdg));
        chk("wr_granted", 64'(wrg), 64'(m_wrg));
        chk("l2_rd_en", 64'(l2_rd_en), 64'(|m_rdg));
        chk("l2_wr_en", 64'(l2_wr_en), 64'(|m_wrg));
        chk("l2_addr", 64'(l2_addr), 64'(ea));
        chk("l2_wr_data", 64'(l2_wr_data), 64'(ewd));
        chk("rd_data", 64'(rd_data), 64'(exp_rd));
    endtask

    task automatic advance();
        if (!rst_n) begin
            cur     = -1;
            last    = 1;
            exp_rd  = '0;
            prev_rd = 1'b0;
        end else begin
            if (prev_rd) exp_rd = l2_rd_data;
            prev_rd = |m_rdg;
            if (cur < 0) begin
                if (|(rd_en | wr_en)) begin
                    cur    = pick(rd_en | wr_en);
                    cur_wr = wr_en[cur];
                    beats  = 0;
                end
            end else if (cur_wr || !rd_en[cur]) begin
                last = cur;
                cur  = -1;
            end else begin
                beats++;
                if (beats == BL) begin
                    last = cur;
                    cur  = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        l2_rd_data = $urandom;
    endtask

    task automatic idle_inputs();
        rd_en = '0;
        wr_en = '0;
        addr[0] = '0;
        addr[1] = '0;
        wdata[0] = '0;
        wdata[1] = '0;
    endtask

    initial begin
        tbl[0]  = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0,    32'h0,         2'b00, 2'b00, 32'h0,   32'h0};
        tbl[1]  = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0,    32'h0,         2'b01, 2'b00, 32'h100, 32'h0};
        tbl[2]  = '{2'b01, 2'b00, 32'h101, 32'h0,   32'h0,    32'h0,         2'b01, 2'b00, 32'h101, 32'h0};
        tbl[3]  = '{2'b01, 2'b00, 32'h102, 32'h0,   32'h0,    32'h0,         2'b01, 2'b00, 32'h102, 32'h0};
        tbl[4]  = '{2'b01, 2'b00, 32'h103, 32'h0,   32'h0,    32'h0,         2'b01, 2'b00, 32'h103, 32'h0};
        tbl[5]  = '{2'b00, 2'b10, 32'h0,   32'h40,  32'h0,    32'hDEADBEEF,  2'b00, 2'b00, 32'h0,   32'h0};
        tbl[6]  = '{2'b00, 2'b10, 32'h0,   32'h40,  32'h0,    32'hDEADBEEF,  2'b00, 2'b10, 32'h40,  32'hDEADBEEF};
        tbl[7]  = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,    32'h0,         2'b00, 2'b00, 32'h0,   32'h0};
        tbl[8]  = '{2'b01, 2'b00, 32'h200, 32'h0,   32'h0,    32'h0,         2'b00, 2'b00, 32'h0,   32'h0};
        tbl[9]  = '{2'b01, 2'b00, 32'h200, 32'h0,   32'h0,    32'h0,         2'b01, 2'b00, 32'h200, 32'h0};
        tbl[10] = '{2'b11, 2'b00, 32'h201, 32'h300, 32'h0,    32'h0,         2'b01, 2'b00, 32'h201, 32'h0};
        tbl[11] = '{2'b10, 2'b00, 32'h202, 32'h300, 32'h0,    32'h0,         2'b00, 2'b00, 32'h0,   32'h0};
        tbl[12] = '{2'b10, 2'b00, 32'h0,   32'h300, 32'h0,    32'h0,         2'b00, 2'b00, 32'h0,   32'h0};
        tbl[13] = '{2'b10, 2'b00, 32'h0,   32'h300, 32'h0,    32'h0,         2'b10, 2'b00, 32'h300, 32'h0};
        tbl[14] = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,    32'h0,         2'b00, 2'b00, 32'h0,   32'h0};
        tbl[15] = '{2'b00, 2'b01, 32'h50,  32'h0,   32'h1234, 32'h0,         2'b00, 2'b00, 32'h0,   32'h0};
        tbl[16] = '{2'b00, 2'b00, 32'h50,  32'h0,   32'h1234, 32'h0,         2'b00, 2'b01, 32'h50,  32'h1234};
        tbl[17] = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,    32'h0,         2'b00, 2'b00, 32'h0,   32'h0};
`ifdef L2_ARB_FIXED_PRIO_EN
        alt_exp = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
        tie_exp = 2'b10;
`else
        alt_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        tie_exp = 2'b01;
`endif
        idle_inputs();
        l2_rd_data = 32'h5555AAAA;
        exp_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_grants", 64'({rdg, wrg}), 64'h0);
        chk("reset_strobes", 64'({l2_rd_en, l2_wr_en}), 64'h0);
        chk("reset_l2_addr", 64'(l2_addr), 64'h0);
        chk("reset_wr_data", 64'(l2_wr_data), 64'h0);
        chk("reset_rd_data", 64'(rd_data), 64'h0);
        advance();
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            rd_en = tbl[i].rd;
            wr_en = tbl[i].wr;
            addr[0] = tbl[i].a0;
            addr[1] = tbl[i].a1;
            wdata[0] = tbl[i].d0;
            wdata[1] = tbl[i].d1;
            sample();
            chk($sformatf("vec%0d_rd_granted", i), 64'(rdg), 64'(tbl[i].erg));
            chk($sformatf("vec%0d_wr_granted", i), 64'(wrg), 64'(tbl[i].ewg));
            chk($sformatf("vec%0d_l2_addr", i), 64'(l2_addr), 64'(tbl[i].ea));
            chk($sformatf("vec%0d_l2_wr_data", i), 64'(l2_wr_data), 64'(tbl[i].ewd));
            advance();
        end

        rst_n = 1'b0;
        sample();
        advance();
        rst_n = 1'b1;
        rd_en = 2'b11;
        addr[0] = 32'h1000;
        addr[1] = 32'h2000;
        for (int i = 0; i < 12; i++) begin
            sample();
            chk($sformatf("alt_cycle%0d", i), 64'(rdg), 64'(alt_exp[i]));
            advance();
        end
        rd_en = '0;
        repeat (2) begin
            sample();
            advance();
        end

        rst_n = 1'b0;
        sample();
        advance();
        rst_n = 1'b1;
        rd_en = 2'b01;
        sample();
        advance();
        sample();
        chk("rst_beat1", 64'(rdg), 64'h1);
        rst_n = 1'b0;
        rd_en = 2'b11;
        advance();
        rst_n = 1'b1;
        sample();
        chk("rst_abort_grants", 64'({rdg, wrg}), 64'h0);
        chk("rst_abort_strobes", 64'({l2_rd_en, l2_wr_en}), 64'h0);
        chk("rst_abort_rd_data", 64'(rd_data), 64'h0);
        advance();
        sample();
        chk("rst_rearb_winner", 64'(rdg), 64'(tie_exp));
        advance();
        idle_inputs();
        repeat (BL + 1) begin
            sample();
            advance();
        end

        for (int i = 0; i < 4000; i++) begin
            rst_n = $urandom_range(63) != 0;
            if ($urandom_range(7) == 0) rd_en = 2'($urandom);
            wr_en = $urandom_range(3) == 0 ? 2'($urandom) : 2'b00;
            addr[0] = $urandom;
            addr[1] = $urandom;
            wdata[0] = $urandom;
            wdata[1] = $urandom;
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
